// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode, branch condition and field constants shared by the
// pipeline controller and its decoder.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {OP_ALU = 2'b00, OP_LI = 2'b01, OP_BR = 2'b10, OP_HALT = 2'b11} op_e;
   typedef enum logic [2:0] {COND_B = 3'b000, COND_BNZ = 3'b001} cond_e;
   localparam logic [15:0] NOP_IR = 16'h0000;
   localparam int OP_LSB   = 14;
   localparam int RD_LSB   = 11;
   localparam int RS1_LSB  = 8;
   localparam int RS2_LSB  = 5;
   localparam int FUNC_LSB = 0;
   typedef struct packed {
      op_e        op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [4:0] func;
      logic       reads_rs1;
      logic       reads_rs2;
      logic       writes_rd;
   } dec_t;
   function automatic op_e op_of(input logic [15:0] ir);
      return op_e'(ir[OP_LSB +: 2]);
   endfunction
   // Bit 0 is operand 1, bit 1 is operand 2; r0 never forwards because writes_rd excludes rd=0.
   function automatic logic [1:0] fwd_of(input dec_t ex, input dec_t wb);
      return {ex.reads_rs2 && ex.rs2 != 3'd0 && wb.writes_rd && ex.rs2 == wb.rd,
              ex.reads_rs1 && ex.rs1 != 3'd0 && wb.writes_rd && ex.rs1 == wb.rd};
   endfunction
endpackage

// File: rtl/pipe_decode.sv
// pipe_decode: combinational field extraction and register-use flags for one
// pipeline stage register.
module pipe_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [15:0] i_ir,
   output dec_t        o_dec
);
   always_comb begin
      o_dec.op        = op_of(i_ir);
      o_dec.rd        = i_ir[RD_LSB +: 3];
      o_dec.rs1       = i_ir[RS1_LSB +: 3];
      o_dec.rs2       = i_ir[RS2_LSB +: 3];
      o_dec.func      = i_ir[FUNC_LSB +: 5];
      o_dec.reads_rs1 = o_dec.op == OP_ALU || o_dec.op == OP_BR;
      o_dec.reads_rs2 = o_dec.op == OP_ALU;
      o_dec.writes_rd = (o_dec.op == OP_ALU || o_dec.op == OP_LI) && o_dec.rd != 3'd0;
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch/ID/EX/WB control for a 16-bit in-order pipeline with
// fetch stalls, taken-branch flush, WB->EX forwarding select and HALT freeze.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP      = NOP_IR
)(
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [15:0] ir_in,
   input  logic        imem_wait,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic [15:0] pc,
   output logic [15:0] pc_ex,
   output logic [15:0] ir_id,
   output logic [15:0] ir_ex,
   output logic [15:0] ir_wb,
   output logic        fwd1,
   output logic        fwd2,
   output logic        wb_en,
   output logic [2:0]  wb_addr,
   output logic        halted
);
   logic [15:0] r_pc, r_pc_id, r_pc_ex, r_ir_id, r_ir_ex, r_ir_wb;
   logic        r_halted;
   logic        w_halt_pend, w_hold_fetch;
   dec_t        w_dec_ex, w_dec_wb;

   pipe_decode u_dec_ex (.i_ir(r_ir_ex), .o_dec(w_dec_ex));
   pipe_decode u_dec_wb (.i_ir(r_ir_wb), .o_dec(w_dec_wb));

   // Fetch stops as soon as HALT enters ID and stays stopped until it retires.
   assign w_halt_pend  = op_of(r_ir_id) == OP_HALT || w_dec_ex.op == OP_HALT || w_dec_wb.op == OP_HALT;
   assign w_hold_fetch = imem_wait || w_halt_pend;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_pc     <= RESET_PC;
         r_pc_id  <= 16'h0000;
         r_pc_ex  <= 16'h0000;
         r_ir_id  <= NOP;
         r_ir_ex  <= NOP;
         r_ir_wb  <= NOP;
         r_halted <= 1'b0;
      end else if (!r_halted) begin
         r_halted <= w_dec_wb.op == OP_HALT;
         r_pc_id  <= r_pc;
         r_pc_ex  <= r_pc_id;
         if (br_taken) begin
            r_pc    <= br_target;
            r_ir_id <= NOP;
            r_ir_ex <= NOP;
            r_ir_wb <= w_dec_ex.op == OP_HALT ? NOP : r_ir_ex;
         end else begin
            r_pc    <= w_hold_fetch ? r_pc : r_pc + 16'd1;
            r_ir_id <= w_hold_fetch ? NOP : ir_in;
            r_ir_ex <= r_ir_id;
            r_ir_wb <= r_ir_ex;
         end
      end
   end

   assign pc           = r_pc;
   assign pc_ex        = r_pc_ex;
   assign ir_id        = r_ir_id;
   assign ir_ex        = r_ir_ex;
   assign ir_wb        = r_ir_wb;
   assign halted       = r_halted;
   assign wb_en        = w_dec_wb.writes_rd;
   assign wb_addr      = w_dec_wb.writes_rd ? w_dec_wb.rd : 3'd0;
   assign {fwd2, fwd1} = fwd_of(w_dec_ex, w_dec_wb);
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-002 Parameter: NOP, 16'h0000, bubble instruction (ADD r0 r0 r0, func 0).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RSTN  in  1  reset, synchronous and active-low.
REQ-005 ir_in  in  16  instruction fetched from address pc this cycle.
REQ-006 imem_wait  in  1  1 = ir_in not valid this cycle.
REQ-007 br_taken  in  1  1 = branch in EX stage resolved taken.
REQ-008 br_target  in  16  branch destination, valid with br_taken.
REQ-009 pc  out  16  current fetch address.
REQ-010 pc_ex  out  16  address of instruction in EX.
REQ-011 ir_id, ir_ex, ir_wb  out  16 each  instruction held in the ID, EX and WB stage registers.
REQ-012 fwd1, fwd2  out  1 each  1 = EX operand 1/2 taken from WB result, not register file.
REQ-013 wb_en  out  1  register write enable for instruction in WB.
REQ-014 wb_addr  out  3  destination register for WB write.
REQ-015 halted  out  1  1 = HALT retired; pipeline frozen.

Function
REQ-016 Decode fields: op=ir[15:14]; 00 ALU (rd=[13:11], rs1=[10:8], rs2=[7:5], func=[4:0]); 01 LI (rd=[13:11], imm=[7:0]); 10 branch (cond=[13:11]: 000 B, 001 BNZ; rs=[10:8]; off=[7:0]); 11 HALT.
REQ-017 Normal advance: ir_id<=ir_in, ir_ex<=ir_id, ir_wb<=ir_ex, pc_ex<=pc of ID instruction, pc<=pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000).
REQ-018 imem_wait=1: pc holds; ir_id<=NOP; EX and WB advance normally.
REQ-019 br_taken=1 at edge t: pc<=br_target; ir_id<=NOP; ir_ex<=NOP; ir_wb<=ir_ex (branch retires); 2-cycle penalty.
REQ-020 br_taken overrides imem_wait and HALT handling in the same cycle.
REQ-021 HALT in ID (no br_taken): pc holds; ir_id<=NOP; HALT advances to EX then WB.
REQ-022 HALT in ID or EX flushed by taken branch is discarded; fetch resumes at br_target.
REQ-023 HALT in WB: halted<=1 next edge; thereafter pc, all stage registers, and halted hold until reset.
REQ-024 wb_en=1 iff ir_wb op is 00 or 01 and rd!=0; wb_addr=rd of ir_wb (0 when wb_en=0).
REQ-025 r0 reads as zero: no forwarding for source register 0.
REQ-026 fwd1=1 iff ir_ex op is 00 or 10, ir_ex rs1/rs field !=0, wb_en=1, equal to wb_addr.
REQ-027 fwd2=1 iff ir_ex op is 00, rs2 !=0, wb_en=1, rs2==wb_addr.
REQ-028 fwd1, fwd2, wb_en, wb_addr combinational from stage registers; no added latency.
REQ-029 Register file write-through (WB write visible to ID read same cycle) is owned by the register file, not this block.

Reset
REQ-030 RSTN=0 at edge: pc<=RESET_PC; ir_id, ir_ex, ir_wb<=NOP; pc_ex<=0; halted<=0.
REQ-031 Reset takes priority over br_taken, imem_wait, halted; mid-flight instructions discarded.
REQ-032 First fetch after RSTN rises uses address RESET_PC.

Structure
REQ-033 Shared package holds opcode constants (OP_ALU, OP_LI, OP_BR, OP_HALT), branch cond codes, NOP, and field bit positions.
REQ-034 One sub-module, pipe_decode: combinational field extract plus reads_rs1/reads_rs2/writes_rd flags, instantiated for EX and WB stages.

Verification
REQ-035 Reset, RESET_PC=8, then LI r6,1 / LI r5,-1 / ADD r4,r2,r3 streamed -> pc 8,9,10,11; each reaches ir_wb 3 cycles after fetch; wb_addr 6,5,4.
REQ-036 LI r2,5 then ADD r4,r2,r3 back-to-back -> fwd1=1, fwd2=0 in the cycle the ADD is in EX.
REQ-037 BNZ r1,-3 at pc 12, br_taken=1, br_target=9 -> next pc=9; ir_id=ir_ex=NOP; 2 NOPs reach WB with wb_en=0.
REQ-038 imem_wait=1 for 2 cycles -> pc holds; 2 NOPs enter ID; older instructions drain.
REQ-039 HALT fetched at pc 20 -> pc holds at 21; halted=1 one cycle after HALT in WB; holds with stimulus applied; RSTN=0 clears.
REQ-040 B taken in EX while HALT in ID -> HALT flushed, halted stays 0, pc=br_target; ADD r0,r1,r1 in WB -> wb_en=0, no forwarding.
